matmul_sequencer: RTL and testbench
===================================

MATMUL_SEQUENCER -- requirements
Module: matmul_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 16, fixed-point word width.
REQ-002 SHALL have parameter CHUNK_SIZE, default 4, words per core lane.
REQ-003 SHALL have parameter NUM_CORES, default 4, cores in the multi-core array.
REQ-004 SHALL have parameter K_STEPS, default 32, operand beats per output tile.
REQ-005 SHALL have parameter NUM_TILES, default 8, output tiles per job.
REQ-006 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-007 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-008 SHALL have port start, input, 1, job request pulse, sampled only in IDLE.
REQ-009 SHALL have port opnd_valid, input, 1, operand memory beat available this cycle.
REQ-010 SHALL have port acc_done, input, 1, array accumulator_done.
REQ-011 SHALL have ports busy, done, and mm_en, mm_reset_acc, opnd_rd, res_we, outputs, 1 bit each.
REQ-012 SHALL have port opnd_addr, output, clog2(NUM_TILES*K_STEPS), operand read address.
REQ-013 SHALL have port res_addr, output, clog2(NUM_TILES*NUM_CORES), result write address.

Function
REQ-014 SHALL implement states IDLE, CLEAR, FEED, WAIT_ACC, DRAIN, DONE.
REQ-015 SHALL leave IDLE for CLEAR when start=1; busy=1 in every state except IDLE.
REQ-016 SHALL assert mm_reset_acc for exactly one cycle in CLEAR, then enter FEED.
REQ-017 SHALL, in FEED, assert opnd_rd=1 when opnd_valid=1, and increment opnd_addr and the beat counter on each such cycle.
REQ-018 SHALL assert mm_en one cycle after each accepted beat (registered, matching 1-cycle memory latency); mm_en=0 otherwise.
REQ-019 SHALL hold the counters and opnd_rd=0 when opnd_valid=0 in FEED (stall, no beat lost).
REQ-020 SHALL enter WAIT_ACC after the K_STEPS-th accepted beat, with mm_en still pulsing once for that beat.
REQ-021 SHALL leave WAIT_ACC for DRAIN on the first cycle acc_done=1; acc_done in any other state SHALL be ignored.
REQ-022 SHALL, in DRAIN, assert res_we for exactly NUM_CORES consecutive cycles, incrementing res_addr after each.
REQ-023 SHALL, after DRAIN, return to CLEAR if tiles remain, else enter DONE.
REQ-024 SHALL assert done for exactly one cycle in DONE, then return to IDLE; opnd_addr and res_addr SHALL reset to 0 on IDLE entry.
REQ-025 SHALL ignore start while busy=1 (no queuing).
REQ-026 SHALL NOT wrap either address within a job; the final values are NUM_TILES*K_STEPS-1 and NUM_TILES*NUM_CORES-1.
REQ-027 SHALL give K_STEPS=1 and NUM_TILES=1 correct behaviour: one beat, one drain, done.

Reset
REQ-028 SHALL, when rst=1 at a clock edge, enter IDLE and drive every output to 0, including both addresses and all counters, regardless of the current state.
REQ-029 SHALL let rst take priority over start in the same cycle; no memory or result write SHALL occur in the cycle after reset.

Structure
REQ-030 SHALL place the state enum and the address-width functions in the shared matmul package.
REQ-031 SHALL use one sub-module, seq_counter (load-zero, enable, terminal-count flag), instanced for the beat, tile and drain counters.

Verification
REQ-032 SHALL cover the nominal job. Stimulus: K_STEPS=4, NUM_TILES=2, NUM_CORES=4, opnd_valid=1, acc_done 3 cycles after the last beat. Response: 8 opnd_rd, 8 mm_en, 2 mm_reset_acc pulses, 8 res_we with res_addr 0..7, one done.
REQ-033 SHALL cover stalls. Stimulus: opnd_valid low every other cycle. Response: opnd_addr 0..7 with no skip or repeat, and mm_en count 8.
REQ-034 SHALL cover start while busy. Stimulus: start pulsed during FEED. Response: no effect on counters; exactly one done.
REQ-035 SHALL cover reset mid-job. Stimulus: rst in DRAIN. Response: next cycle IDLE with all outputs 0; a new start gives a full job from address 0.
REQ-036 SHALL cover a spurious acc_done. Stimulus: acc_done=1 in FEED. Response: no transition to DRAIN; beat count unaffected.

Source files
------------

// File: rtl/matmul_sequencer_pkg.sv
// Shared types and address-width helpers for the matmul operand/result sequencer.
package matmul_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_FEED,
    ST_WAIT_ACC,
    ST_DRAIN,
    ST_DONE
  } seq_state_e;

  // Widths never collapse to zero so single-tile, single-beat builds stay legal.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned opnd_aw(input int unsigned tiles, input int unsigned k_steps);
    return clog2_min1(tiles * k_steps);
  endfunction

  function automatic int unsigned res_aw(input int unsigned tiles, input int unsigned cores);
    return clog2_min1(tiles * cores);
  endfunction

endpackage

// File: rtl/matmul_sequencer_seq_counter.sv
// Modulo-MAX counter with synchronous clear, enable and a terminal-count flag.
module seq_counter
  import matmul_sequencer_pkg::*;
#(
  parameter int unsigned MAX = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_c_o
);

  localparam int unsigned CW = clog2_min1(MAX);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tc_c_o = (cnt_q == CW'(MAX - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = tc_c_o ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/matmul_sequencer.sv
// Sequences operand reads, accumulator clears and result drains for a tiled
// matrix multiply on a multi-core array.
module matmul_sequencer
  import matmul_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned CHUNK_SIZE = 4,
  parameter int unsigned NUM_CORES  = 4,
  parameter int unsigned K_STEPS    = 32,
  parameter int unsigned NUM_TILES  = 8
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     start,
  input  logic                                     opnd_valid,
  input  logic                                     acc_done,
  output logic                                     busy,
  output logic                                     done,
  output logic                                     mm_en,
  output logic                                     mm_reset_acc,
  output logic                                     opnd_rd,
  output logic                                     res_we,
  output logic [opnd_aw(NUM_TILES, K_STEPS)-1:0]   opnd_addr,
  output logic [res_aw(NUM_TILES, NUM_CORES)-1:0]  res_addr
);

  localparam int unsigned OAW = opnd_aw(NUM_TILES, K_STEPS);
  localparam int unsigned RAW = res_aw(NUM_TILES, NUM_CORES);

  if (WIDTH == 0 || CHUNK_SIZE == 0 || NUM_CORES == 0 || K_STEPS == 0 || NUM_TILES == 0) begin : g_bad_cfg
    $error("matmul_sequencer: all size parameters must be non-zero");
  end

  seq_state_e     st_q, st_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           mm_en_q, mm_en_d;
  logic           mm_reset_acc_q, mm_reset_acc_d;
  logic           res_we_q, res_we_d;
  logic [OAW-1:0] opnd_addr_q, opnd_addr_d;
  logic [RAW-1:0] res_addr_q, res_addr_d;

  logic accept_c, drain_c, idle_c;
  logic beat_tc_c, tile_tc_c, drain_tc_c;

  assign accept_c = (st_q == ST_FEED) && opnd_valid;
  assign drain_c  = (st_q == ST_DRAIN);
  assign idle_c   = (st_q == ST_IDLE);

  seq_counter #(.MAX(K_STEPS)) u_beat_cnt (
    .clk_i(clk), .rst_i(rst), .clr_i(idle_c), .en_i(accept_c), .tc_c_o(beat_tc_c)
  );

  seq_counter #(.MAX(NUM_TILES)) u_tile_cnt (
    .clk_i(clk), .rst_i(rst), .clr_i(idle_c), .en_i(drain_c && drain_tc_c), .tc_c_o(tile_tc_c)
  );

  seq_counter #(.MAX(NUM_CORES)) u_drain_cnt (
    .clk_i(clk), .rst_i(rst), .clr_i(idle_c), .en_i(drain_c), .tc_c_o(drain_tc_c)
  );

  // Next state and next outputs; outputs follow the state being entered.
  always_comb begin
    st_d        = st_q;
    opnd_addr_d = opnd_addr_q;
    res_addr_d  = res_addr_q;
    case (st_q)
      ST_IDLE:     if (start) st_d = ST_CLEAR;
      ST_CLEAR:    st_d = ST_FEED;
      ST_FEED: begin
        if (accept_c) begin
          // The last beat of the job leaves the address on its final value.
          if (!(beat_tc_c && tile_tc_c)) opnd_addr_d = opnd_addr_q + OAW'(1);
          if (beat_tc_c) st_d = ST_WAIT_ACC;
        end
      end
      ST_WAIT_ACC: if (acc_done) st_d = ST_DRAIN;
      ST_DRAIN: begin
        if (!(drain_tc_c && tile_tc_c)) res_addr_d = res_addr_q + RAW'(1);
        if (drain_tc_c) st_d = tile_tc_c ? ST_DONE : ST_CLEAR;
      end
      ST_DONE: begin
        st_d        = ST_IDLE;
        opnd_addr_d = '0;
        res_addr_d  = '0;
      end
      default:     st_d = ST_IDLE;
    endcase
    busy_d         = (st_d != ST_IDLE);
    done_d         = (st_d == ST_DONE);
    mm_reset_acc_d = (st_d == ST_CLEAR);
    res_we_d       = (st_d == ST_DRAIN);
    mm_en_d        = accept_c;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q           <= ST_IDLE;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      mm_en_q        <= 1'b0;
      mm_reset_acc_q <= 1'b0;
      res_we_q       <= 1'b0;
      opnd_addr_q    <= '0;
      res_addr_q     <= '0;
    end else begin
      st_q           <= st_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      mm_en_q        <= mm_en_d;
      mm_reset_acc_q <= mm_reset_acc_d;
      res_we_q       <= res_we_d;
      opnd_addr_q    <= opnd_addr_d;
      res_addr_q     <= res_addr_d;
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign mm_en        = mm_en_q;
  assign mm_reset_acc = mm_reset_acc_q;
  assign res_we       = res_we_q;
  assign opnd_addr    = opnd_addr_q;
  assign res_addr     = res_addr_q;
  assign opnd_rd      = accept_c;

endmodule

// File: tb/tb_matmul_sequencer.sv
// Bench for matmul_sequencer: randomized operand/acc handshakes against a job-level model.
module tb_matmul_sequencer;
  import matmul_sequencer_pkg::*;

  localparam int unsigned K = 4;
  localparam int unsigned T = 2;
  localparam int unsigned C = 4;
  localparam int ACC_DLY = 3;

  logic clk = 1'b0;
  logic rst, start, opnd_valid, acc_done;
  logic busy, done, mm_en, mm_reset_acc, opnd_rd, res_we;
  logic [opnd_aw(T, K)-1:0] opnd_addr;
  logic [res_aw(T, C)-1:0]  res_addr;

  logic s_start, s_valid, s_acc;
  logic s_busy, s_done, s_en, s_rac, s_rd, s_we;
  logic [opnd_aw(1, 1)-1:0] s_oaddr;
  logic [res_aw(1, 2)-1:0]  s_raddr;

  int checks = 0;
  int errors = 0;

  int oq[$];
  int rq[$];
  int n_en, n_rac, n_rac_rise, n_done;
  int n_err_en, n_err_run, n_err_rd, n_err_busy;
  int end_oa, end_ra;
  bit timed_out, aborted;
  logic [7:0] snap_bits;
  int snap_oa, snap_ra;

  always #5 clk = ~clk;

  matmul_sequencer #(
    .WIDTH(16), .CHUNK_SIZE(4), .NUM_CORES(C), .K_STEPS(K), .NUM_TILES(T)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .opnd_valid(opnd_valid), .acc_done(acc_done),
    .busy(busy), .done(done), .mm_en(mm_en), .mm_reset_acc(mm_reset_acc),
    .opnd_rd(opnd_rd), .res_we(res_we), .opnd_addr(opnd_addr), .res_addr(res_addr)
  );

  matmul_sequencer #(
    .WIDTH(16), .CHUNK_SIZE(4), .NUM_CORES(2), .K_STEPS(1), .NUM_TILES(1)
  ) dut1 (
    .clk(clk), .rst(rst), .start(s_start), .opnd_valid(s_valid), .acc_done(s_acc),
    .busy(s_busy), .done(s_done), .mm_en(s_en), .mm_reset_acc(s_rac),
    .opnd_rd(s_rd), .res_we(s_we), .opnd_addr(s_oaddr), .res_addr(s_raddr)
  );

  // Model: a job reads addresses 0..n-1 in order exactly once each.
  function automatic bit seq_ok(input int q[$], input int n);
    if (q.size() != n) return 1'b0;
    foreach (q[i]) if (q[i] != i) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int last_of(input int q[$]);
    return (q.size() == 0) ? -1 : q[q.size()-1];
  endfunction

  // Drives one job and records everything observed; vmode 0=always valid, 1=alternate, 2=random.
  task automatic run_job(input int vmode, input bit spur, input bit start_feed, input bit rst_drain);
    int cyc = 0;
    int tile_beats = 0;
    int acc_cd = 0;
    int run = 0;
    int post = 0;
    int rst_stage = 0;
    bit prev_acc = 1'b0;
    bit prev_rr = 1'b0;
    bit seen_done = 1'b0;
    bit fired = 1'b0;
    oq.delete(); rq.delete();
    n_en = 0; n_rac = 0; n_rac_rise = 0; n_done = 0;
    n_err_en = 0; n_err_run = 0; n_err_rd = 0; n_err_busy = 0;
    timed_out = 1'b0; aborted = 1'b0; end_oa = -1; end_ra = -1;
    @(negedge clk);
    start = 1'b1; opnd_valid = 1'b0; acc_done = 1'b0;
    while (1) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (rst_stage == 1) begin
        rst = 1'b1; opnd_valid = 1'b0; acc_done = 1'b0; rst_stage = 2;
        continue;
      end
      if (rst_stage == 2) begin
        rst = 1'b0;
        #1;
        snap_bits = {2'b00, busy, done, mm_en, mm_reset_acc, opnd_rd, res_we};
        snap_oa = int'(opnd_addr); snap_ra = int'(res_addr);
        aborted = 1'b1;
        return;
      end
      case (vmode)
        0:       opnd_valid = 1'b1;
        1:       opnd_valid = (cyc % 2) != 0;
        default: opnd_valid = ($urandom_range(0, 3) != 0);
      endcase
      if (acc_cd > 0) begin
        acc_cd--;
        acc_done = (acc_cd == 0);
      end else begin
        acc_done = spur && tile_beats > 0 && tile_beats < int'(K) && ($urandom_range(0, 1) == 1);
      end
      if (start_feed && !fired && tile_beats > 0 && tile_beats < int'(K)) begin
        start = 1'b1; fired = 1'b1;
      end
      #1;
      if (opnd_rd && !opnd_valid) n_err_rd++;
      if (mm_en !== prev_acc) n_err_en++;
      if (mm_en) n_en++;
      prev_acc = opnd_rd;
      if (opnd_rd) begin
        oq.push_back(int'(opnd_addr));
        tile_beats++;
        if (tile_beats == int'(K)) begin
          tile_beats = 0;
          acc_cd = ACC_DLY;
        end
      end
      if (mm_reset_acc) n_rac++;
      if (mm_reset_acc && !prev_rr) n_rac_rise++;
      prev_rr = mm_reset_acc;
      if (res_we) begin
        rq.push_back(int'(res_addr));
        run++;
      end else if (run != 0) begin
        if (run != int'(C)) n_err_run++;
        run = 0;
      end
      if (seen_done) begin
        if (busy) n_err_busy++;
      end else if (!busy) begin
        n_err_busy++;
      end
      if (done) begin
        n_done++;
        seen_done = 1'b1;
      end
      if (rst_drain && rst_stage == 0 && rq.size() >= 1) rst_stage = 1;
      if (seen_done) post++;
      if (post >= 4) begin
        end_oa = int'(opnd_addr); end_ra = int'(res_addr);
        return;
      end
      if (cyc > 600) begin
        timed_out = 1'b1;
        return;
      end
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    rst = 1'b1; start = 1'b1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    #1;
    checks++;
    if ({busy, done, mm_en, mm_reset_acc, opnd_rd, res_we} !== 6'b0 || opnd_addr !== '0 || res_addr !== '0) begin
      errors++;
      $display("FAIL reset_outputs got ctl=%b oa=%0d ra=%0d want all 0",
               {busy, done, mm_en, mm_reset_acc, opnd_rd, res_we}, opnd_addr, res_addr);
    end
    @(negedge clk);
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_beats_start busy=%b want 0", busy);
    end
  endtask

  task automatic test_nominal;
    run_job(0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (timed_out !== 1'b0) begin errors++; $display("FAIL nominal_timeout got=%b want 0", timed_out); end
    checks++;
    if (seq_ok(oq, int'(T*K)) !== 1'b1) begin
      errors++; $display("FAIL nominal_opnd_addr got n=%0d last=%0d want 0..%0d", oq.size(), last_of(oq), T*K-1);
    end
    checks++;
    if (seq_ok(rq, int'(T*C)) !== 1'b1) begin
      errors++; $display("FAIL nominal_res_addr got n=%0d last=%0d want 0..%0d", rq.size(), last_of(rq), T*C-1);
    end
    checks++;
    if (n_en !== int'(T*K)) begin errors++; $display("FAIL nominal_mm_en got=%0d want %0d", n_en, T*K); end
    checks++;
    if (n_rac !== int'(T) || n_rac_rise !== int'(T)) begin
      errors++; $display("FAIL nominal_reset_acc got cycles=%0d pulses=%0d want %0d", n_rac, n_rac_rise, T);
    end
    checks++;
    if (n_done !== 1) begin errors++; $display("FAIL nominal_done got=%0d want 1", n_done); end
    checks++;
    if (n_err_en !== 0 || n_err_run !== 0) begin
      errors++; $display("FAIL nominal_timing got mm_en_err=%0d drain_run_err=%0d want 0", n_err_en, n_err_run);
    end
    checks++;
    if (n_err_busy !== 0) begin errors++; $display("FAIL nominal_busy got err=%0d want 0", n_err_busy); end
    checks++;
    if (end_oa !== 0 || end_ra !== 0) begin
      errors++; $display("FAIL nominal_idle_addr got oa=%0d ra=%0d want 0", end_oa, end_ra);
    end
  endtask

  task automatic test_stall;
    run_job(1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (timed_out !== 1'b0) begin errors++; $display("FAIL stall_timeout got=%b want 0", timed_out); end
    checks++;
    if (seq_ok(oq, int'(T*K)) !== 1'b1) begin
      errors++; $display("FAIL stall_opnd_addr got n=%0d last=%0d want 0..%0d", oq.size(), last_of(oq), T*K-1);
    end
    checks++;
    if (n_en !== int'(T*K) || n_err_en !== 0) begin
      errors++; $display("FAIL stall_mm_en got count=%0d err=%0d want %0d/0", n_en, n_err_en, T*K);
    end
    checks++;
    if (n_err_rd !== 0) begin errors++; $display("FAIL stall_rd_without_valid got=%0d want 0", n_err_rd); end
    checks++;
    if (n_done !== 1) begin errors++; $display("FAIL stall_done got=%0d want 1", n_done); end
  endtask

  task automatic test_random;
    for (int r = 0; r < 3; r++) begin
      run_job(2, 1'b0, 1'b0, 1'b0);
      checks++;
      if (seq_ok(oq, int'(T*K)) !== 1'b1 || timed_out !== 1'b0) begin
        errors++; $display("FAIL random%0d_opnd_addr got n=%0d last=%0d to=%b want 0..%0d", r, oq.size(), last_of(oq), timed_out, T*K-1);
      end
      checks++;
      if (seq_ok(rq, int'(T*C)) !== 1'b1 || n_err_run !== 0) begin
        errors++; $display("FAIL random%0d_res_addr got n=%0d last=%0d run_err=%0d want 0..%0d", r, rq.size(), last_of(rq), n_err_run, T*C-1);
      end
      checks++;
      if (n_done !== 1 || n_err_en !== 0) begin
        errors++; $display("FAIL random%0d_done got done=%0d mm_en_err=%0d want 1/0", r, n_done, n_err_en);
      end
    end
  endtask

  task automatic test_start_busy;
    run_job(0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (seq_ok(oq, int'(T*K)) !== 1'b1 || timed_out !== 1'b0) begin
      errors++; $display("FAIL start_busy_opnd_addr got n=%0d last=%0d want 0..%0d", oq.size(), last_of(oq), T*K-1);
    end
    checks++;
    if (n_done !== 1) begin errors++; $display("FAIL start_busy_done got=%0d want 1", n_done); end
    checks++;
    if (n_rac !== int'(T) || n_en !== int'(T*K)) begin
      errors++; $display("FAIL start_busy_counts got rac=%0d en=%0d want %0d/%0d", n_rac, n_en, T, T*K);
    end
    checks++;
    if (n_err_busy !== 0) begin errors++; $display("FAIL start_busy_restart got err=%0d want 0", n_err_busy); end
  endtask

  task automatic test_spurious_acc;
    run_job(2, 1'b1, 1'b0, 1'b0);
    checks++;
    if (seq_ok(oq, int'(T*K)) !== 1'b1 || timed_out !== 1'b0) begin
      errors++; $display("FAIL spurious_opnd_addr got n=%0d last=%0d want 0..%0d", oq.size(), last_of(oq), T*K-1);
    end
    checks++;
    if (seq_ok(rq, int'(T*C)) !== 1'b1 || n_err_run !== 0) begin
      errors++; $display("FAIL spurious_drain got n=%0d run_err=%0d want %0d/0", rq.size(), n_err_run, T*C);
    end
    checks++;
    if (n_en !== int'(T*K) || n_done !== 1) begin
      errors++; $display("FAIL spurious_counts got en=%0d done=%0d want %0d/1", n_en, n_done, T*K);
    end
  endtask

  task automatic test_reset_mid_job;
    run_job(0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (aborted !== 1'b1) begin errors++; $display("FAIL rst_drain_reached got=%b want 1", aborted); end
    checks++;
    if (snap_bits !== 8'h00 || snap_oa !== 0 || snap_ra !== 0) begin
      errors++; $display("FAIL rst_drain_outputs got ctl=%b oa=%0d ra=%0d want 0", snap_bits, snap_oa, snap_ra);
    end
    run_job(0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (seq_ok(oq, int'(T*K)) !== 1'b1 || seq_ok(rq, int'(T*C)) !== 1'b1) begin
      errors++; $display("FAIL rst_drain_rerun got oq=%0d/%0d rq=%0d/%0d want full job from 0",
                         oq.size(), last_of(oq), rq.size(), last_of(rq));
    end
    checks++;
    if (n_done !== 1 || timed_out !== 1'b0) begin
      errors++; $display("FAIL rst_drain_rerun_done got=%0d to=%b want 1", n_done, timed_out);
    end
  endtask

  task automatic test_single;
    int n_rd = 0, n_en1 = 0, n_we = 0, n_dn = 0, n_rc = 0, bad = 0, cd = 0;
    @(negedge clk);
    s_start = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      s_start = 1'b0;
      s_valid = 1'b1;
      if (cd > 0) begin
        cd--;
        s_acc = (cd == 0);
      end else begin
        s_acc = 1'b0;
      end
      #1;
      if (s_rd) begin
        n_rd++;
        if (s_oaddr !== '0) bad++;
        cd = 2;
      end
      if (s_en) n_en1++;
      if (s_rac) n_rc++;
      if (s_we) begin
        if (int'(s_raddr) !== n_we) bad++;
        n_we++;
      end
      if (s_done) n_dn++;
    end
    checks++;
    if (n_rd !== 1 || n_en1 !== 1) begin errors++; $display("FAIL single_beat got rd=%0d en=%0d want 1/1", n_rd, n_en1); end
    checks++;
    if (n_rc !== 1) begin errors++; $display("FAIL single_reset_acc got=%0d want 1", n_rc); end
    checks++;
    if (n_we !== 2 || bad !== 0) begin errors++; $display("FAIL single_drain got we=%0d addr_err=%0d want 2/0", n_we, bad); end
    checks++;
    if (n_dn !== 1) begin errors++; $display("FAIL single_done got=%0d want 1", n_dn); end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; opnd_valid = 1'b0; acc_done = 1'b0;
    s_start = 1'b0; s_valid = 1'b0; s_acc = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    test_reset;
    test_nominal;
    test_stall;
    test_random;
    test_start_busy;
    test_spurious_acc;
    test_reset_mid_job;
    test_single;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
